// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: per-channel GPIO pad front end.
//
// Sits between the GPIO peripheral and the bidirectional pad cells. It sequences
// direction turnaround so the pad driver (OEN low) and receiver (IE high) are
// never enabled together. It also synchronises and optionally debounces the pad
// receiver output, reports filtered edges, and keeps a sticky edge flag per
// channel with an OR-reduced interrupt.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active-high
//   gpio_out_i     output data from the peripheral
//   gpio_dir_i     direction request, 1 = output, 0 = input
//   pe_i, ds_hi_i  pull enable / high drive strength requests
//   db_en_i        per-channel debounce enable
//   db_len_i       shared debounce threshold in cycles
//   evt_clr_i      write-1-to-clear for the sticky edge flags
//   pad_c_i        pad receiver outputs
//   pad_i_o        pad driver data
//   pad_oen_o      pad output enable, active-low
//   pad_ie_o       pad input enable
//   pad_pe_o       pad pull enable
//   pad_ds_o       pad drive strength
//   gpio_in_o      filtered input value to the peripheral
//   rise_o, fall_o one-cycle pulses on filtered edges
//   evt_sticky_o   sticky edge flags
//   irq_o          OR of the sticky flags
//
// Direction FSM (one per channel)
//   state     | meaning
//   ST_IN     | receiver enabled, driver off, input filtering active
//   ST_TO_OUT | both off, waiting out the turnaround gap before driving
//   ST_OUT    | driver enabled, receiver off, input filtering frozen
//   ST_TO_IN  | both off, waiting out the turnaround gap before receiving

module gpio_pad_ctrl #(
   parameter int N_GPIO      = 11,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 8,
   parameter int TURN_CYC    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_GPIO-1:0] gpio_out_i,
   input  logic [N_GPIO-1:0] gpio_dir_i,
   input  logic [N_GPIO-1:0] pe_i,
   input  logic [N_GPIO-1:0] ds_hi_i,
   input  logic [N_GPIO-1:0] db_en_i,
   input  logic [DB_W-1:0]   db_len_i,
   input  logic [N_GPIO-1:0] evt_clr_i,
   input  logic [N_GPIO-1:0] pad_c_i,
   output logic [N_GPIO-1:0] pad_i_o,
   output logic [N_GPIO-1:0] pad_oen_o,
   output logic [N_GPIO-1:0] pad_ie_o,
   output logic [N_GPIO-1:0] pad_pe_o,
   output logic [N_GPIO-1:0] pad_ds_o,
   output logic [N_GPIO-1:0] gpio_in_o,
   output logic [N_GPIO-1:0] rise_o,
   output logic [N_GPIO-1:0] fall_o,
   output logic [N_GPIO-1:0] evt_sticky_o,
   output logic              irq_o
);

   localparam int TC_W = $clog2(TURN_CYC + 1);
   localparam logic [TC_W-1:0] TC_LOAD = TC_W'(TURN_CYC);
   localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);

   typedef enum logic [1:0] {
      ST_IN     = 2'd0,
      ST_TO_OUT = 2'd1,
      ST_OUT    = 2'd2,
      ST_TO_IN  = 2'd3
   } dir_state_t;

   dir_state_t        state_q [N_GPIO];
   dir_state_t        state_d [N_GPIO];
   logic [TC_W-1:0]   tc_q    [N_GPIO];
   logic [TC_W-1:0]   tc_d    [N_GPIO];
   logic [N_GPIO-1:0] oen_d;
   logic [N_GPIO-1:0] ie_d;

   // ---------------------------------------------------------------- FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_GPIO; i++) begin
            state_q[i] <= ST_IN;
            tc_q[i]    <= '0;
         end
         pad_oen_o <= '1;
         pad_ie_o  <= '1;
      end else begin
         for (int i = 0; i < N_GPIO; i++) begin
            state_q[i] <= state_d[i];
            tc_q[i]    <= tc_d[i];
         end
         pad_oen_o <= oen_d;
         pad_ie_o  <= ie_d;
      end
   end

   // ---------------------------------------------------------------- FSM next state
   // A direction reversal during a turnaround returns straight to the state it
   // came from, so an aborted TO_OUT never drives the pad.
   always_comb begin
      for (int i = 0; i < N_GPIO; i++) begin
         state_d[i] = state_q[i];
         tc_d[i]    = tc_q[i];
         case (state_q[i])
            ST_IN: begin
               if (gpio_dir_i[i]) begin
                  state_d[i] = ST_TO_OUT;
                  tc_d[i]    = TC_LOAD;
               end
            end
            ST_TO_OUT: begin
               if (!gpio_dir_i[i])         state_d[i] = ST_IN;
               else if (tc_q[i] == TC_ONE) state_d[i] = ST_OUT;
               else                        tc_d[i]    = tc_q[i] - TC_ONE;
            end
            ST_OUT: begin
               if (!gpio_dir_i[i]) begin
                  state_d[i] = ST_TO_IN;
                  tc_d[i]    = TC_LOAD;
               end
            end
            ST_TO_IN: begin
               if (gpio_dir_i[i])          state_d[i] = ST_OUT;
               else if (tc_q[i] == TC_ONE) state_d[i] = ST_IN;
               else                        tc_d[i]    = tc_q[i] - TC_ONE;
            end
            default: state_d[i] = ST_IN;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM outputs
   // Pad controls are registered from the next state so they line up with it.
   always_comb begin
      oen_d = '1;
      ie_d  = '0;
      for (int i = 0; i < N_GPIO; i++) begin
         oen_d[i] = (state_d[i] != ST_OUT);
         ie_d[i]  = (state_d[i] == ST_IN);
      end
   end

   // ---------------------------------------------------------------- pad control pass-through
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pad_i_o  <= '0;
         pad_pe_o <= '0;
         pad_ds_o <= '0;
      end else begin
         pad_i_o  <= gpio_out_i;
         pad_pe_o <= pe_i;
         pad_ds_o <= ds_hi_i;
      end
   end

   // ---------------------------------------------------------------- input synchroniser
   logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
   logic [N_GPIO-1:0] sync_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pad_c_i;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------- debounce filter
   logic [N_GPIO-1:0] filt_q;
   logic [N_GPIO-1:0] filt_d;
   logic [DB_W-1:0]   cnt_q [N_GPIO];
   logic [DB_W-1:0]   cnt_d [N_GPIO];
   logic              db_long;

   // Thresholds of 0 or 1 behave as no debounce.
   assign db_long = (db_len_i > DB_W'(1));

   // The threshold compare is done one bit wider so a counter at its maximum
   // cannot wrap, and a threshold lowered mid-count takes effect at once.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < N_GPIO; i++) begin
         cnt_d[i] = '0;
         if (state_q[i] == ST_IN) begin
            if (!db_en_i[i] || !db_long) begin
               filt_d[i] = sync_s[i];
            end else if (sync_s[i] != filt_q[i]) begin
               if (({1'b0, cnt_q[i]} + (DB_W+1)'(1)) >= {1'b0, db_len_i})
                  filt_d[i] = sync_s[i];
               else
                  cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------- filtered value, edges, sticky flags
   // Sticky flags are set from the registered edge pulses, so a clear issued in
   // the cycle a pulse is visible loses to that pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q       <= '0;
         rise_o       <= '0;
         fall_o       <= '0;
         evt_sticky_o <= '0;
         for (int i = 0; i < N_GPIO; i++) cnt_q[i] <= '0;
      end else begin
         filt_q       <= filt_d;
         rise_o       <= filt_d & ~filt_q;
         fall_o       <= ~filt_d & filt_q;
         evt_sticky_o <= (evt_sticky_o & ~evt_clr_i) | rise_o | fall_o;
         for (int i = 0; i < N_GPIO; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign gpio_in_o = filt_q;
   assign irq_o     = |evt_sticky_o;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: expectations are queued with their due cycle
// when stimulus is driven and compared when that cycle is reached.
module tb_gpio_pad_ctrl;

   localparam int N    = 11;
   localparam int SYNC = 2;
   localparam int DBW  = 8;
   localparam int TURN = 2;

   localparam int S_OEN  = 0;
   localparam int S_IE   = 1;
   localparam int S_GIN  = 2;
   localparam int S_RISE = 3;
   localparam int S_FALL = 4;
   localparam int S_STK  = 5;
   localparam int S_IRQ  = 6;
   localparam int S_PI   = 7;
   localparam int S_PE   = 8;
   localparam int S_DS   = 9;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   gpio_out, gpio_dir, pe, ds_hi, db_en, evt_clr, pad_c;
   logic [DBW-1:0] db_len;
   logic [N-1:0]   pad_i, pad_oen, pad_ie, pad_pe, pad_ds, gpio_in, rise, fall, evt_sticky;
   logic           irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int         due;
      int         sel;
      logic [N-1:0] mask;
      logic [N-1:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   gpio_pad_ctrl #(
      .N_GPIO(N), .SYNC_STAGES(SYNC), .DB_W(DBW), .TURN_CYC(TURN)
   ) dut (
      .clk(clk), .rst(rst),
      .gpio_out_i(gpio_out), .gpio_dir_i(gpio_dir), .pe_i(pe), .ds_hi_i(ds_hi),
      .db_en_i(db_en), .db_len_i(db_len), .evt_clr_i(evt_clr), .pad_c_i(pad_c),
      .pad_i_o(pad_i), .pad_oen_o(pad_oen), .pad_ie_o(pad_ie), .pad_pe_o(pad_pe),
      .pad_ds_o(pad_ds), .gpio_in_o(gpio_in), .rise_o(rise), .fall_o(fall),
      .evt_sticky_o(evt_sticky), .irq_o(irq)
   );

   // Driver-on with receiver-on must never be seen on any channel.
   always @(negedge clk) begin
      n_tests++;
      assert (((~pad_oen) & pad_ie) === '0) else begin
         n_fail++;
         $error("FAIL oen_ie_overlap: observed oen=%h ie=%h required no oen=0 with ie=1", pad_oen, pad_ie);
      end
   end

   function automatic logic [N-1:0] get_sig(int sel);
      case (sel)
         S_OEN:   return pad_oen;
         S_IE:    return pad_ie;
         S_GIN:   return gpio_in;
         S_RISE:  return rise;
         S_FALL:  return fall;
         S_STK:   return evt_sticky;
         S_IRQ:   return {{(N-1){1'b0}}, irq};
         S_PI:    return pad_i;
         S_PE:    return pad_pe;
         default: return pad_ds;
      endcase
   endfunction

   task automatic compare(int sel, logic [N-1:0] mask, logic [N-1:0] val, string tag);
      logic [N-1:0] obs;
      logic [N-1:0] exp_v;
      obs   = get_sig(sel) & mask;
      exp_v = val & mask;
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic expect_sig(int dly, int sel, logic [N-1:0] mask, logic [N-1:0] val, string tag);
      exp_t e;
      e.due  = cyc + dly;
      e.sel  = sel;
      e.mask = mask;
      e.val  = val;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
               compare(sb[i].sel, sb[i].mask, sb[i].val, sb[i].tag);
               sb.delete(i);
            end
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      gpio_out = '0; gpio_dir = '0; pe = '0; ds_hi = '0;
      db_en    = '0; db_len = '0; evt_clr = '0; pad_c = '0;
      step(3);

      compare(S_OEN, '1, '1, "reset_oen");
      compare(S_IE,  '1, '1, "reset_ie");
      compare(S_PI,  '1, '0, "reset_pad_i");
      compare(S_GIN, '1, '0, "reset_gpio_in");
      compare(S_STK, '1, '0, "reset_sticky");
      compare(S_IRQ, '1, '0, "reset_irq");
      rst = 1'b0;

      // pass-through of driver data, pull and drive strength
      gpio_out = 11'h2A5; pe = 11'h155; ds_hi = 11'h0F0;
      expect_sig(1, S_PI, '1, 11'h2A5, "pad_i_pass");
      expect_sig(1, S_PE, '1, 11'h155, "pad_pe_pass");
      expect_sig(1, S_DS, '1, 11'h0F0, "pad_ds_pass");
      step(1);
      gpio_out = 11'h75A; pe = 11'h000; ds_hi = 11'h70F;
      expect_sig(1, S_PI, '1, 11'h75A, "pad_i_pass2");
      expect_sig(1, S_PE, '1, 11'h000, "pad_pe_pass2");
      expect_sig(1, S_DS, '1, 11'h70F, "pad_ds_pass2");
      step(1);

      // all channels to output
      gpio_dir = '1;
      expect_sig(1, S_IE,  '1, '0, "all_ie_low");
      expect_sig(1, S_OEN, '1, '1, "all_oen_gap1");
      expect_sig(2, S_OEN, '1, '1, "all_oen_gap2");
      expect_sig(3, S_OEN, '1, '0, "all_oen_low");
      step(4);

      // asynchronous reset while driving
      #3;
      rst = 1'b1;
      #1;
      compare(S_OEN, '1, '1, "async_rst_oen");
      compare(S_IE,  '1, '1, "async_rst_ie");
      compare(S_IRQ, '1, '0, "async_rst_irq");
      step(2);
      rst = 1'b0;
      gpio_dir = 11'h001;
      expect_sig(1, S_IE,  11'h001, 11'h000, "ch0_ie_low");
      expect_sig(1, S_IE,  11'h7FE, 11'h7FE, "others_ie_high");
      expect_sig(1, S_OEN, 11'h001, 11'h001, "ch0_oen_gap1");
      expect_sig(2, S_OEN, 11'h001, 11'h001, "ch0_oen_gap2");
      expect_sig(3, S_OEN, 11'h001, 11'h000, "ch0_oen_low");
      step(4);

      // ch3 turnaround aborted during TO_OUT
      gpio_dir = 11'h009;
      expect_sig(1, S_IE,  11'h008, 11'h000, "ch3_ie_low");
      expect_sig(1, S_OEN, 11'h008, 11'h008, "ch3_oen_held1");
      step(1);
      gpio_dir = 11'h001;
      expect_sig(1, S_IE,  11'h008, 11'h008, "ch3_ie_back");
      for (int d = 1; d <= 3; d++) expect_sig(d, S_OEN, 11'h008, 11'h008, "ch3_oen_held");
      step(4);

      // ch1 rising edge without debounce
      pad_c = 11'h002;
      expect_sig(2, S_GIN,  11'h002, 11'h000, "ch1_in_early");
      expect_sig(3, S_GIN,  11'h002, 11'h002, "ch1_in");
      expect_sig(2, S_RISE, 11'h002, 11'h000, "ch1_rise_early");
      expect_sig(3, S_RISE, 11'h002, 11'h002, "ch1_rise");
      expect_sig(4, S_RISE, 11'h002, 11'h000, "ch1_rise_end");
      expect_sig(3, S_STK,  11'h002, 11'h000, "ch1_sticky_early");
      expect_sig(4, S_STK,  11'h002, 11'h002, "ch1_sticky");
      expect_sig(4, S_IRQ,  11'h001, 11'h001, "irq_set");
      step(4);
      evt_clr = 11'h002;
      expect_sig(1, S_STK, 11'h002, 11'h000, "ch1_clr");
      expect_sig(1, S_IRQ, 11'h001, 11'h000, "irq_clr1");
      step(1);
      evt_clr = '0;
      step(1);

      // ch2 debounce, threshold 5: 4-cycle glitch rejected
      db_en  = 11'h004;
      db_len = 8'd5;
      pad_c  = 11'h006;
      for (int d = 1; d <= 12; d++) begin
         expect_sig(d, S_GIN,  11'h004, 11'h000, "ch2_glitch_in");
         expect_sig(d, S_RISE, 11'h004, 11'h000, "ch2_glitch_rise");
      end
      step(4);
      pad_c = 11'h002;
      step(8);

      // ch2 held high long enough
      pad_c = 11'h006;
      expect_sig(6, S_GIN,  11'h004, 11'h000, "ch2_db_in_early");
      expect_sig(7, S_GIN,  11'h004, 11'h004, "ch2_db_in");
      expect_sig(6, S_RISE, 11'h004, 11'h000, "ch2_db_rise_early");
      expect_sig(7, S_RISE, 11'h004, 11'h004, "ch2_db_rise");
      step(8);
      evt_clr = 11'h004;
      step(1);
      evt_clr = '0;

      // ch4 frozen while driving
      gpio_dir = 11'h011;
      expect_sig(3, S_OEN, 11'h010, 11'h000, "ch4_oen_low");
      step(3);
      pad_c = 11'h016;
      for (int d = 1; d <= 12; d++) begin
         expect_sig(d, S_GIN,  11'h010, 11'h000, "ch4_frozen_in");
         expect_sig(d, S_RISE, 11'h010, 11'h000, "ch4_frozen_rise");
         expect_sig(d, S_FALL, 11'h010, 11'h000, "ch4_frozen_fall");
      end
      step(3);
      pad_c = 11'h006;
      step(3);
      pad_c = 11'h016;
      step(6);

      // ch4 back to input with pad high and filtered value low
      gpio_dir = 11'h001;
      expect_sig(1, S_OEN, 11'h010, 11'h010, "ch4_oen_off");
      expect_sig(2, S_IE,  11'h010, 11'h000, "ch4_ie_gap");
      expect_sig(3, S_IE,  11'h010, 11'h010, "ch4_ie_on");
      for (int d = 1; d <= 3; d++) expect_sig(d, S_RISE, 11'h010, 11'h000, "ch4_rise_early");
      expect_sig(4, S_RISE, 11'h010, 11'h010, "ch4_rise_reentry");
      expect_sig(4, S_GIN,  11'h010, 11'h010, "ch4_in_reentry");
      expect_sig(5, S_RISE, 11'h010, 11'h000, "ch4_rise_once");
      step(6);
      evt_clr = 11'h010;
      step(1);
      evt_clr = '0;

      // ch5 clear colliding with a fall pulse
      pad_c = 11'h036;
      step(4);
      evt_clr = 11'h020;
      expect_sig(1, S_STK, 11'h020, 11'h000, "ch5_pre_clr");
      step(1);
      evt_clr = '0;
      pad_c = 11'h016;
      expect_sig(3, S_FALL, 11'h020, 11'h020, "ch5_fall");
      expect_sig(3, S_GIN,  11'h020, 11'h000, "ch5_in_low");
      expect_sig(3, S_STK,  11'h020, 11'h000, "ch5_sticky_before");
      step(3);
      evt_clr = 11'h020;
      expect_sig(1, S_STK, 11'h020, 11'h020, "ch5_set_wins");
      step(1);
      evt_clr = '0;
      expect_sig(1, S_STK, 11'h020, 11'h020, "ch5_sticky_hold");
      step(1);
      evt_clr = 11'h020;
      expect_sig(1, S_STK, 11'h020, 11'h000, "ch5_clr_after");
      expect_sig(1, S_IRQ, 11'h001, 11'h000, "irq_clr_final");
      step(1);
      evt_clr = '0;
      step(2);

      n_tests++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
Parametrised per-channel GPIO pad front end that sits between the SoC GPIO peripheral and the bidirectional pad cells in the pad-ring wrapper, replacing hard-wired pad control hookup. It sequences direction turnaround so input and output drivers are never enabled together. It also synchronises and debounces pad inputs, detects edges, and raises a sticky edge interrupt.

Parameters:
N_GPIO, 11, number of GPIO channels/pads
SYNC_STAGES, 2, input synchroniser depth (>=2)
DB_W, 8, debounce counter/threshold width
TURN_CYC, 2, direction turnaround gap in cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
gpio_out_i  in  N_GPIO  output data from GPIO peripheral
gpio_dir_i  in  N_GPIO  1 = output, 0 = input
pe_i  in  N_GPIO  pull enable request
ds_hi_i  in  N_GPIO  high drive strength request
db_en_i  in  N_GPIO  per-channel debounce enable
db_len_i  in  DB_W  shared debounce threshold in cycles
evt_clr_i  in  N_GPIO  write-1-to-clear for sticky events
pad_c_i  in  N_GPIO  pad receiver outputs (C)
pad_i_o  out  N_GPIO  pad driver data (I)
pad_oen_o  out  N_GPIO  pad output enable, active-low (OEN)
pad_ie_o  out  N_GPIO  pad input enable (IE)
pad_pe_o  out  N_GPIO  pad pull enable (PE)
pad_ds_o  out  N_GPIO  pad drive strength (DS)
gpio_in_o  out  N_GPIO  filtered input value to peripheral
rise_o  out  N_GPIO  1-cycle pulse on filtered rising edge
fall_o  out  N_GPIO  1-cycle pulse on filtered falling edge
evt_sticky_o  out  N_GPIO  sticky edge flag
irq_o  out  1  OR of evt_sticky_o

Behaviour:
- All outputs registered except irq_o (OR of registered sticky flags). Reset values: pad_oen_o=all 1, pad_ie_o=all 1, pad_i_o/pad_pe_o/pad_ds_o/gpio_in_o/rise_o/fall_o/evt_sticky_o=0, irq_o=0. Internal synchroniser flops, filtered value, debounce and turnaround counters reset to 0. FSM resets to IN.
- pad_i_o, pad_pe_o, pad_ds_o: gpio_out_i, pe_i, ds_hi_i registered, 1-cycle latency, in every state.
- Per-channel direction FSM. States: IN, TO_OUT, OUT, TO_IN. Turnaround counter tc is loaded with TURN_CYC.
- IN: oen=1, ie=1. If dir=1: go to TO_OUT, ie<=0, load tc.
- TO_OUT: oen=1, ie=0, tc decrements. When tc reaches 1: go to OUT, oen<=0. If dir=0 during TO_OUT: go to IN, ie<=1; oen is never asserted.
- OUT: oen=0, ie=0. If dir=0: go to TO_IN, oen<=1, load tc.
- TO_IN: oen=1, ie=0, tc decrements. When tc reaches 1: go to IN, ie<=1. If dir=1 during TO_IN: go to OUT, oen<=0.
- Invariant: oen=0 and ie=1 never hold together. From input to output, oen goes low TURN_CYC+1 cycles after dir rises.
- Input path: pad_c_i passes through a SYNC_STAGES flop chain to give s. Filtered value f drives gpio_in_o.
- No debounce (db_en=0) or db_len<=1: f<=s every cycle. Latency from pad_c_i to gpio_in_o is SYNC_STAGES+1.
- Debounce (db_en=1, db_len>=2), each cycle:
  - s==f: cnt<=0.
  - s!=f and cnt+1>=db_len: f<=s, cnt<=0.
  - otherwise cnt<=cnt+1.
  - A glitch shorter than db_len cycles is rejected. Latency is SYNC_STAGES+db_len. db_len changes take effect immediately via the >= compare.
- Freeze: in any state other than IN, f holds, cnt is held at 0 and no edges are generated. The synchroniser keeps running. On re-entry to IN, normal filtering resumes from the current s.
- rise_o/fall_o pulse in the same cycle gpio_in_o changes 0->1 / 1->0.
- evt_sticky set by rise or fall, cleared by evt_clr_i. Set and clear in the same cycle: set wins.
- Async reset mid-turnaround forces IN immediately: oen=1, ie=1.

Test Plan:
- Reset: assert rst while dir=all 1 and in OUT -> same-cycle pad_oen_o=0x7FF, pad_ie_o=0x7FF, irq_o=0. After release, ch0 dir=1 -> pad_ie_o[0]=0 after 1 cycle, pad_oen_o[0]=0 after 3 cycles.
- Turnaround abort: ch3 dir 0->1, then back to 0 one cycle later (TO_OUT) -> pad_oen_o[3] stays 1 throughout, pad_ie_o[3] returns to 1. Checker asserts !(~oen & ie) every cycle on all channels.
- No debounce: ch1 pad_c 0->1 -> gpio_in_o[1]=1 and rise_o[1] pulse exactly 3 cycles later. evt_sticky_o[1]=1, irq_o=1. evt_clr_i[1] -> cleared next cycle.
- Debounce, db_len=5: ch2 4-cycle high glitch -> gpio_in_o[2] stays 0, no event. 5-cycle high -> gpio_in_o[2]=1 at 2+5=7 cycles after the pad edge.
- Freeze: ch4 in OUT, pad_c toggles -> no rise/fall. Return to input with pad_c=1 and f=0 -> rise_o[4] once after IN re-entry plus 1 cycle.
- Set/clear collision: evt_clr_i[5] in the same cycle as a fall_o[5] pulse -> evt_sticky_o[5]=1.
